// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the riscv data port, the DMA/loader requester and the single-port dmem.
// The arbiter takes the slave view; the environment driving requests and dmem read data takes the master view.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_last;
    logic          dma_gnt;
    logic [DW-1:0] dma_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_last,
        input  mem_rdata,
        output cpu_gnt, cpu_stall, cpu_rdata,
        output dma_gnt, dma_rdata,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_last,
        output mem_rdata,
        input  cpu_gnt, cpu_stall, cpu_rdata,
        input  dma_gnt, dma_rdata,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between the CPU data port and a DMA requester; ownership parks on the CPU,
// DMA bursts are capped at MAX_BURST beats. Define DMEM_ARB_RR_EN for CPU/DMA round-robin.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int            CW       = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_BURST - 1);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    owner_e        r_owner;
    owner_e        w_owner_nxt;
    logic [CW-1:0] r_beat_cnt;
    logic [CW-1:0] w_beat_cnt_nxt;
    logic          w_sel_dma;
    logic          w_cpu_gnt;
    logic          w_dma_gnt;
    logic          w_dma_release;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;

    // Reset masks both grants and steers the mux back to the CPU in the same cycle.
    assign w_sel_dma     = (r_owner == OWN_DMA) & ~reset;
    assign w_cpu_gnt     = (r_owner == OWN_CPU) & bus.cpu_req & ~reset;
    assign w_dma_gnt     = w_sel_dma & bus.dma_req;
    assign w_dma_release = bus.dma_last | (r_beat_cnt == LAST_IDX);
    assign w_mem_addr    = w_sel_dma ? bus.dma_addr  : bus.cpu_addr;
    assign w_mem_wdata   = w_sel_dma ? bus.dma_wdata : bus.cpu_wdata;

    assign bus.cpu_gnt   = w_cpu_gnt;
    assign bus.cpu_stall = bus.cpu_req & ~w_cpu_gnt;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dma_gnt   = w_dma_gnt;
    assign bus.dma_rdata = bus.mem_rdata;
    assign bus.mem_we    = (w_cpu_gnt & bus.cpu_we) | (w_dma_gnt & bus.dma_we);
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    // NOTE: every next-state signal gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        if (r_owner == OWN_CPU) begin
`ifdef DMEM_ARB_RR_EN
            if (bus.dma_req & (~bus.cpu_req | w_cpu_gnt)) begin
`else
            if (bus.dma_req & ~bus.cpu_req) begin
`endif
                w_owner_nxt    = OWN_DMA;
                w_beat_cnt_nxt = '0;
            end
        end else begin
            // An idle DMA cycle or a final/capped beat hands the memory straight back.
            if (w_dma_gnt & ~w_dma_release) begin
                w_beat_cnt_nxt = r_beat_cnt + CW'(1);
            end else begin
                w_owner_nxt    = OWN_CPU;
                w_beat_cnt_nxt = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= OWN_CPU;
            r_beat_cnt <= '0;
        end else begin
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

`ifdef DMEM_ARB_RR_EN
    logic r_last_dma;

    // Owner of the previous cycle, kept for status/debug visibility.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_dma <= 1'b0;
        end else begin
            r_last_dma <= (r_owner == OWN_DMA);
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random traffic, checked against a
// cycle-level reference model of ownership and a shadow copy of dmem.
module tb_dmem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // dmem: combinational read, write at the clock edge.
    logic [DW-1:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    typedef struct {
        logic          cg;
        logic          dg;
        logic          st;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          chk_crd;
        logic          chk_drd;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t          q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] ref_mem [256];

    // Reference model: who holds the memory and how many beats the DMA has finished in this burst.
    bit dma_owns    = 1'b0;
    int beats_done  = 0;
    bit g_cg;
    bit g_dg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit creq, input bit cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input bit dreq, input bit dwe,
                         input logic [31:0] daddr, input logic [31:0] dwd, input bit dlast);
        exp_t e;
        reset         = rst;
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = cwd;
        bus.dma_req   = dreq;
        bus.dma_we    = dwe;
        bus.dma_addr  = daddr;
        bus.dma_wdata = dwd;
        bus.dma_last  = dlast;

        e.cg      = !rst && !dma_owns && creq;
        e.dg      = !rst && dma_owns && dreq;
        e.st      = creq && !e.cg;
        e.we      = (e.cg && cwe) || (e.dg && dwe);
        e.addr    = (!rst && dma_owns) ? daddr : caddr;
        e.wd      = (!rst && dma_owns) ? dwd : cwd;
        e.rd      = ref_mem[e.addr[9:2]];
        e.chk_crd = e.cg && !cwe;
        e.chk_drd = e.dg && !dwe;
        q.push_back(e);
        g_cg = e.cg;
        g_dg = e.dg;
        if (e.we) ref_mem[e.addr[9:2]] = e.wd;

        if (rst) begin
            dma_owns   = 1'b0;
            beats_done = 0;
        end else if (!dma_owns) begin
`ifdef DMEM_ARB_RR_EN
            // Round-robin: a waiting DMA always gets the next turn after a CPU-owned cycle.
            if (dreq) begin
`else
            if (dreq && !creq) begin
`endif
                dma_owns   = 1'b1;
                beats_done = 0;
            end
        end else if (e.dg) begin
            beats_done++;
            if (dlast || beats_done >= MAXB) begin
                dma_owns   = 1'b0;
                beats_done = 0;
            end
        end else begin
            dma_owns   = 1'b0;
            beats_done = 0;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    // One DMA burst of n beats; the DMA only advances when granted. Optionally a CPU access
    // is raised once the DMA owns the memory at beat cpu_k, and reset is pulsed at beat rst_k.
    task automatic dma_burst(input logic [31:0] base, input int n, input bit we, input bit use_last,
                             input int cpu_k, input bit cwe, input logic [31:0] caddr,
                             input logic [31:0] cwd, input int rst_k);
        int k        = 0;
        bit cpu_pend = 0;
        bit cpu_done = 0;
        bit rst_done = 0;
        for (int cyc = 0; cyc < 8 * n + 20 && k < n; cyc++) begin
            bit r;
            if (cpu_k >= 0 && k >= cpu_k && dma_owns && !cpu_done) cpu_pend = 1;
            r = (rst_k >= 0 && k == rst_k && dma_owns && !rst_done);
            drive(r, cpu_pend, cwe, caddr, cwd, 1, we, base + 32'(k * 4),
                  32'hD000_0000 + base + 32'(k), use_last && (k == n - 1));
            if (r) rst_done = 1;
            if (g_cg) begin
                cpu_pend = 0;
                cpu_done = 1;
            end
            if (g_dg) k++;
        end
        check("dma_burst_beats", 32'(k), 32'(n));
        idle(1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("cpu_gnt", 32'(bus.cpu_gnt), 32'(e.cg));
                check("dma_gnt", 32'(bus.dma_gnt), 32'(e.dg));
                check("cpu_stall", 32'(bus.cpu_stall), 32'(e.st));
                check("mem_we", 32'(bus.mem_we), 32'(e.we));
                check("mem_addr", bus.mem_addr, e.addr);
                if (e.we) check("mem_wdata", bus.mem_wdata, e.wd);
                if (e.chk_crd) check("cpu_rdata", bus.cpu_rdata, e.rd);
                if (e.chk_drd) check("dma_rdata", bus.dma_rdata, e.rd);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        reset = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0; bus.dma_last = 0;
        @(posedge clk);
        #1;

        // Reset with both requesters active: no grant, no write, mux on CPU.
        drive(1, 1, 1, 32'h10, 32'h55, 1, 1, 32'h80, 32'h66, 0);
        // CPU write with DMA idle, granted in the same cycle.
        drive(0, 1, 1, 32'h10, 32'hAA, 0, 0, 32'h0, 32'h0, 0);
        drive(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        // 3-beat DMA write burst ending on dma_last.
        dma_burst(32'h20, 3, 1, 1, -1, 0, 32'h0, 32'h0, -1);
        // 10 beats without dma_last: capped at MAXB, CPU interleaves once.
        dma_burst(32'h100, 10, 1, 0, 1, 0, 32'h24, 32'h0, -1);
        // Simultaneous requests held for 6 cycles from CPU ownership.
        for (int i = 0; i < 6; i++) drive(0, 1, 0, 32'h20, 32'h0, 1, 0, 32'h28, 32'h0, 0);
        idle(2);
        // Reset at beat 2 of a 5-beat DMA write; the remainder is reissued.
        dma_burst(32'h200, 5, 1, 1, -1, 0, 32'h0, 32'h0, 1);
        // DMA read of a CPU-written word while the CPU waits on another read.
        drive(0, 1, 1, 32'h40, 32'h1234, 0, 0, 32'h0, 32'h0, 0);
        dma_burst(32'h40, 1, 0, 1, 0, 0, 32'h44, 32'h0, -1);
        // MAXB-beat read burst whose cap and dma_last coincide.
        dma_burst(32'h100, MAXB, 0, 1, -1, 0, 32'h0, 32'h0, -1);

        // Random traffic, including idle DMA gaps, mid-burst resets and random dma_last.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] ca;
            logic [31:0] da;
            ca = {22'd0, 8'($urandom), 2'b00};
            da = {22'd0, 8'($urandom), 2'b00};
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0, 1'($urandom),
                  ca, $urandom, $urandom_range(0, 3) != 0, 1'($urandom), da, $urandom,
                  $urandom_range(0, 5) == 0);
        end
        idle(2);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
